regfile_dump_reader: RTL and testbench

- Sequential reader on the register file's read side. It walks R0..R(NUM_REGS-1) through one source-select port and captures each combinational read value.
- Each captured value is presented to a downstream consumer (hex display driver, debug memory writer) over a valid/ready handshake.
- It sits beside the register file in the datapath and drives that file's SR select input. It never drives LD_REG.

---
 rtl/regfile_dump_reader.sv | 72 +++++++
 tb/tb_regfile_dump_reader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks R0..R(NUM_REGS-1) through the SR select port and streams each read value over valid/ready
module regfile_dump_reader #(
   parameter int NUM_REGS = 8,
   parameter int IDX_W    = 3,
   parameter int DATA_W   = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Abort,
   output logic [IDX_W-1:0]  SR_sel,
   input  logic [DATA_W-1:0] SR_data,
   output logic              Dump_valid,
   input  logic              Dump_ready,
   output logic [DATA_W-1:0] Dump_data,
   output logic [IDX_W-1:0]  Dump_idx,
   output logic              Busy,
   output logic              Done
);
   typedef enum logic [1:0] {IDLE, SELECT, PRESENT, DONE} state_t;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS - 1);
   state_t state;
   // SR_sel doubles as the index counter; it returns to 0 whenever the walk ends
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         state      <= IDLE;
         SR_sel     <= '0;
         Dump_valid <= 1'b0;
         Dump_data  <= '0;
         Dump_idx   <= '0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
      end else begin
         Done <= 1'b0;
         if (state != IDLE && Abort) begin
            state      <= IDLE;
            SR_sel     <= '0;
            Dump_valid <= 1'b0;
            Busy       <= 1'b0;
         end else
            case (state)
               IDLE:
                  if (Start) begin
                     state  <= SELECT;
                     SR_sel <= '0;
                     Busy   <= 1'b1;
                  end
               SELECT: begin
                  Dump_data  <= SR_data;
                  Dump_idx   <= SR_sel;
                  Dump_valid <= 1'b1;
                  state      <= PRESENT;
               end
               PRESENT:
                  if (Dump_ready) begin
                     Dump_valid <= 1'b0;
                     if (SR_sel == LAST) begin
                        state <= DONE;
                        Done  <= 1'b1;
                     end else begin
                        SR_sel <= SR_sel + IDX_W'(1);
                        state  <= SELECT;
                     end
                  end
               DONE: begin
                  state  <= IDLE;
                  SR_sel <= '0;
                  Busy   <= 1'b0;
               end
            endcase
      end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: step-counter reference model, per-cycle compare and directed plus random stimulus
module tb_regfile_dump_reader;
   localparam int N = 8;
   logic Clk = 0, Reset = 0, Start = 0, Abort = 0, Dump_ready = 0;
   logic [2:0]  SR_sel, Dump_idx;
   logic [15:0] SR_data, Dump_data;
   logic Dump_valid, Busy, Done;
   logic [15:0] rf [N];
   int n_cmp = 0, n_bad = 0;
   int step = -1;
   logic [15:0] cap = '0;
   int busy_cnt = 0, done_cnt = 0;
   logic [15:0] xd[$];
   logic [2:0]  xi[$];

   always #5 Clk = ~Clk;
   assign SR_data = rf[SR_sel];

   regfile_dump_reader #(.NUM_REGS(N), .IDX_W(3), .DATA_W(16)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .SR_sel(SR_sel), .SR_data(SR_data),
      .Dump_valid(Dump_valid), .Dump_ready(Dump_ready), .Dump_data(Dump_data), .Dump_idx(Dump_idx),
      .Busy(Busy), .Done(Done));

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: step -1 idle; even step 2k selects reg k; odd step presents it; step 2N is the Done cycle
   always @(posedge Clk or posedge Reset)
      if (Reset) begin step = -1; cap = '0; end
      else if (step >= 0 && Abort) step = -1;
      else if (step < 0) begin if (Start) step = 0; end
      else if (step == 2*N) step = -1;
      else if (step % 2 == 0) begin cap = rf[step/2]; step++; end
      else if (Dump_ready) step++;

   always @(negedge Clk) begin
      chk("busy", Busy, step >= 0);
      chk("done", Done, step == 2*N);
      chk("valid", Dump_valid, step >= 0 && step % 2 == 1);
      if (step < 0) chk("sr_sel_idle", SR_sel, 0);
      else if (step < 2*N) chk("sr_sel", SR_sel, step/2);
      if (step >= 0 && step % 2 == 1) begin
         chk("dump_idx", Dump_idx, step/2);
         chk("dump_data", Dump_data, cap);
      end
      if (Busy) busy_cnt++;
      if (Done) done_cnt++;
   end

   always @(posedge Clk)
      if (!Reset && Dump_valid && Dump_ready) begin xd.push_back(Dump_data); xi.push_back(Dump_idx); end

   task automatic tick(); @(posedge Clk); #1; endtask
   task automatic clear(); busy_cnt = 0; done_cnt = 0; xd.delete(); xi.delete(); endtask
   task automatic preload(); for (int i = 0; i < N; i++) rf[i] = 16'h1000 + 16'(i); endtask
   task automatic start_pulse(); Start = 1; tick(); Start = 0; endtask
   task automatic wait_idle();
      int k = 0;
      while (Busy && k < 500) begin tick(); k++; end
      chk("idle_timeout", Busy, 0);
      tick();
   endtask
   task automatic wait_item(int idx);
      int k = 0;
      while (!(Dump_valid && Dump_idx == 3'(idx)) && k < 200) begin tick(); k++; end
      chk("item_timeout", Dump_valid && Dump_idx == 3'(idx), 1);
   endtask
   task automatic check_full(string nm, int busy_exp);
      chk({nm, "_count"}, xi.size(), N);
      for (int i = 0; i < N && i < xi.size(); i++) begin
         chk({nm, "_idx"}, xi[i], i);
         chk({nm, "_data"}, xd[i], 16'h1000 + 16'(i));
      end
      chk({nm, "_busy"}, busy_cnt, busy_exp);
      chk({nm, "_done"}, done_cnt, 1);
   endtask

   initial begin
      preload();
      #1 Reset = 1;
      tick(); tick();
      Reset = 0;
      chk("rst_busy", Busy, 0); chk("rst_valid", Dump_valid, 0); chk("rst_data", Dump_data, 0);
      chk("rst_idx", Dump_idx, 0); chk("rst_sel", SR_sel, 0); chk("rst_done", Done, 0);
      // full dump, ready high
      Dump_ready = 1; clear();
      start_pulse();
      chk("lat_edge1", Dump_valid, 0);
      tick();
      chk("lat_edge2", Dump_valid, 1);
      wait_idle();
      check_full("t1", 17);
      // stall on item 3 for 5 cycles
      clear(); start_pulse();
      wait_item(3);
      Dump_ready = 0;
      for (int c = 0; c < 5; c++) begin
         chk("stall_valid", Dump_valid, 1); chk("stall_data", Dump_data, 16'h1003);
         chk("stall_idx", Dump_idx, 3); chk("stall_sel", SR_sel, 3);
         tick();
      end
      Dump_ready = 1;
      wait_idle();
      check_full("t2", 22);
      // abort during item 4, then a fresh dump
      clear(); start_pulse();
      wait_item(4);
      Abort = 1; tick(); Abort = 0;
      chk("abort_busy", Busy, 0); chk("abort_valid", Dump_valid, 0); chk("abort_sel", SR_sel, 0);
      repeat (4) tick();
      chk("abort_done", done_cnt, 0);
      clear(); start_pulse();
      wait_idle();
      check_full("t3", 17);
      // Start while busy ignored
      clear(); start_pulse();
      wait_item(2);
      start_pulse();
      wait_idle();
      check_full("t4", 17);
      // coherence: capture-time value kept, later registers read live
      clear(); start_pulse();
      wait_item(2);
      Dump_ready = 0;
      rf[5] = 16'hBEEF; tick();
      rf[2] = 16'h0000; tick();
      chk("coh_held", Dump_data, 16'h1002);
      Dump_ready = 1;
      wait_idle();
      chk("coh_count", xd.size(), N);
      if (xd.size() == N) begin chk("coh_item2", xd[2], 16'h1002); chk("coh_item5", xd[5], 16'hBEEF); end
      // asynchronous reset between edges
      preload(); clear(); start_pulse();
      wait_item(3);
      Dump_ready = 0;
      #2 Reset = 1;
      #1;
      chk("arst_busy", Busy, 0); chk("arst_valid", Dump_valid, 0); chk("arst_data", Dump_data, 0);
      chk("arst_idx", Dump_idx, 0); chk("arst_sel", SR_sel, 0); chk("arst_done", Done, 0);
      tick(); tick();
      Reset = 0;
      repeat (4) tick();
      chk("arst_stay_idle", Busy, 0);
      // random traffic against the model
      for (int c = 0; c < 1500; c++) begin
         Dump_ready = ($urandom_range(0, 3) != 0);
         Start = ($urandom_range(0, 7) == 0);
         Abort = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, N-1)] = 16'($urandom);
         tick();
      end
      Start = 0; Abort = 0;
      tick(); tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
